// File: rtl/csr_unit_pkg.sv
// Shared types and constants for the machine-mode CSR file and trap controller.
package csr_unit_pkg;

    typedef enum logic [2:0] {
        CSR_OP_NONE = 3'd0,
        CSR_OP_RW   = 3'd1,
        CSR_OP_RS   = 3'd2,
        CSR_OP_RC   = 3'd3,
        CSR_OP_RWI  = 3'd5,
        CSR_OP_RSI  = 3'd6,
        CSR_OP_RCI  = 3'd7
    } csr_op_t;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_t;

    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VALUE = 32'h4010_0100;

    localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U     = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
    localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIP_MTIP       = 7;

    // Only M and U exist; the reserved encodings collapse to U.
    function automatic priv_t legalize_mpp(input logic [1:0] v);
        return (v == 2'b11) ? PRIV_M : PRIV_U;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independent half writes; used for mcycle and minstret.
// Only present when CSR_COUNTERS_EN is defined.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A half write wins over the increment for that cycle.
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[31:0]  = wdata;
            if (wr_hi) count_d[63:32] = wdata;
        end else if (inc) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller (M and U privilege only).
// Optional feature macro: CSR_COUNTERS_EN adds mcycle/minstret (64-bit).
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_instr_i,
    input  logic [11:0] csr_addr_i,
    input  csr_op_t     csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    input  logic        ex_ecall_i,
    input  logic        ex_ebreak_i,
    input  logic        ex_mret_i,
    input  logic        ex_illegal_i,
    input  logic        instret_i,
    input  logic        timer_irq_i,
    output logic        trap_redirect_o,
    output logic [31:0] trap_pc_o,
    output logic        csr_illegal_o,
    output logic [1:0]  priv_mode_o,
    output logic [31:0] satp_o
);

    priv_t       priv_q, priv_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    priv_t       mstatus_mpp_q, mstatus_mpp_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] satp_q, satp_d;

    logic [31:0] csr_rdata;
    logic        csr_impl;
    logic        is_write;
    logic [31:0] csr_wnew;
    logic        csr_illegal;
    logic        trap_en;
    logic        take_trap;
    logic        mret_take;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        csr_we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_cnt;
    logic [63:0] minstret_cnt;
`endif

    // Read mux and implemented-address decode.
    always_comb begin
        csr_rdata = '0;
        csr_impl  = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]                   = mstatus_mie_q;
                csr_rdata[MSTATUS_MPIE]                  = mstatus_mpie_q;
                csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mstatus_mpp_q;
            end
            CSR_MISA:     csr_rdata = MISA_VALUE;
            CSR_MIE:      csr_rdata[MIE_MTIE] = mie_mtie_q;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP:      csr_rdata[MIP_MTIP] = timer_irq_i;
            CSR_SATP:     csr_rdata = satp_q;
            CSR_MHARTID:  csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata = mcycle_cnt[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_cnt[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_cnt[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_cnt[63:32];
`endif
            default:      csr_impl = 1'b0;
        endcase
    end

    // Write intent and merged write value; set/clear with zero mask is a pure read.
    always_comb begin
        is_write = 1'b0;
        csr_wnew = csr_rdata;
        case (csr_op_i)
            CSR_OP_RW, CSR_OP_RWI: begin
                is_write = 1'b1;
                csr_wnew = csr_wdata_i;
            end
            CSR_OP_RS, CSR_OP_RSI: begin
                is_write = |csr_wdata_i;
                csr_wnew = csr_rdata | csr_wdata_i;
            end
            CSR_OP_RC, CSR_OP_RCI: begin
                is_write = |csr_wdata_i;
                csr_wnew = csr_rdata & ~csr_wdata_i;
            end
            default: begin
                is_write = 1'b0;
                csr_wnew = csr_rdata;
            end
        endcase
    end

    // Access legality: unimplemented, insufficient privilege, or write to read-only space.
    always_comb begin
        csr_illegal = !rst && (csr_op_i != CSR_OP_NONE) &&
                      (!csr_impl ||
                       (csr_addr_i[9:8] > priv_q) ||
                       (is_write && csr_addr_i[11:10] == 2'b11));
    end

    // Trap priority resolution and redirect target.
    always_comb begin
        trap_en    = !stall && !rst;
        take_trap  = 1'b0;
        trap_cause = '0;
        trap_tval  = '0;
        if (trap_en) begin
            if (ex_valid_i && mstatus_mie_q && mie_mtie_q && timer_irq_i) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_M_TIMER_IRQ;
                trap_tval  = '0;
            end else if (ex_illegal_i || csr_illegal ||
                         (ex_mret_i && priv_q == PRIV_U)) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_ILLEGAL;
                trap_tval  = ex_instr_i;
            end else if (ex_ecall_i) begin
                take_trap  = 1'b1;
                trap_cause = (priv_q == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
                trap_tval  = '0;
            end else if (ex_ebreak_i) begin
                take_trap  = 1'b1;
                trap_cause = CAUSE_BREAKPOINT;
                trap_tval  = ex_pc_i;
            end
        end
        mret_take = trap_en && !take_trap && ex_mret_i && (priv_q == PRIV_M);
        csr_we    = trap_en && is_write && !csr_illegal && !take_trap && !mret_take;
    end

    // Next architectural state: trap, then MRET, then the plain CSR write.
    always_comb begin
        priv_d         = priv_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mstatus_mpp_d  = mstatus_mpp_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        satp_d         = satp_q;
        if (take_trap) begin
            mepc_d         = {ex_pc_i[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mstatus_mpp_d  = priv_q;
            priv_d         = PRIV_M;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            priv_d         = mstatus_mpp_q;
            mstatus_mpp_d  = PRIV_U;
        end else if (csr_we) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wnew[MSTATUS_MIE];
                    mstatus_mpie_d = csr_wnew[MSTATUS_MPIE];
                    mstatus_mpp_d  = legalize_mpp(csr_wnew[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                end
                CSR_MIE:      mie_mtie_d = csr_wnew[MIE_MTIE];
                CSR_MTVEC:    mtvec_d    = {csr_wnew[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = csr_wnew;
                CSR_MEPC:     mepc_d     = {csr_wnew[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = csr_wnew;
                CSR_MTVAL:    mtval_d    = csr_wnew;
                CSR_SATP:     satp_d     = csr_wnew;
                default: ;
            endcase
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            priv_q         <= PRIV_M;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mstatus_mpp_q  <= PRIV_U;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            satp_q         <= '0;
        end else begin
            priv_q         <= priv_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mstatus_mpp_q  <= mstatus_mpp_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            satp_q         <= satp_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (!stall),
        .wr_lo   (csr_we && csr_addr_i == CSR_MCYCLE),
        .wr_hi   (csr_we && csr_addr_i == CSR_MCYCLEH),
        .wdata   (csr_wnew),
        .count_o (mcycle_cnt)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (instret_i && !stall),
        .wr_lo   (csr_we && csr_addr_i == CSR_MINSTRET),
        .wr_hi   (csr_we && csr_addr_i == CSR_MINSTRETH),
        .wdata   (csr_wnew),
        .count_o (minstret_cnt)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

    assign csr_rdata_o     = rst ? 32'd0 : csr_rdata;
    assign csr_illegal_o   = csr_illegal;
    assign trap_redirect_o = take_trap || mret_take;
    assign trap_pc_o       = take_trap ? mtvec_q : (mret_take ? mepc_q : 32'd0);
    assign priv_mode_o     = priv_q;
    assign satp_o          = satp_q;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: the driver queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_csr_unit;
    import csr_unit_pkg::*;

    localparam int S_RDATA = 0;
    localparam int S_ILL   = 1;
    localparam int S_RED   = 2;
    localparam int S_TPC   = 3;
    localparam int S_PRIV  = 4;
    localparam int S_SATP  = 5;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [11:0] csr_addr;
    csr_op_t     csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        ex_ecall, ex_ebreak, ex_mret, ex_illegal;
    logic        instret;
    logic        timer_irq;
    logic        trap_redirect;
    logic [31:0] trap_pc;
    logic        csr_illegal;
    logic [1:0]  priv_mode;
    logic [31:0] satp;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    csr_unit #(.MTVEC_RESET(32'h0), .HART_ID(32'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_valid_i      (ex_valid),
        .ex_pc_i         (ex_pc),
        .ex_instr_i      (ex_instr),
        .csr_addr_i      (csr_addr),
        .csr_op_i        (csr_op),
        .csr_wdata_i     (csr_wdata),
        .csr_rdata_o     (csr_rdata),
        .ex_ecall_i      (ex_ecall),
        .ex_ebreak_i     (ex_ebreak),
        .ex_mret_i       (ex_mret),
        .ex_illegal_i    (ex_illegal),
        .instret_i       (instret),
        .timer_irq_i     (timer_irq),
        .trap_redirect_o (trap_redirect),
        .trap_pc_o       (trap_pc),
        .csr_illegal_o   (csr_illegal),
        .priv_mode_o     (priv_mode),
        .satp_o          (satp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pick(input int sig);
        case (sig)
            S_RDATA: return csr_rdata;
            S_ILL:   return {31'd0, csr_illegal};
            S_RED:   return {31'd0, trap_redirect};
            S_TPC:   return trap_pc;
            S_PRIV:  return {30'd0, priv_mode};
            default: return satp;
        endcase
    endfunction

    // Monitor: outputs are settled mid-cycle, so compare every queued expectation here.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = exp_q.pop_front();
            act = pick(e.sig);
            n_assert++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input int sig, input logic [31:0] v, input string name);
        exp_t e;
        e.sig  = sig;
        e.val  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        stall      = 1'b0;
        ex_valid   = 1'b0;
        ex_pc      = 32'd0;
        ex_instr   = 32'd0;
        csr_addr   = 12'd0;
        csr_op     = CSR_OP_NONE;
        csr_wdata  = 32'd0;
        ex_ecall   = 1'b0;
        ex_ebreak  = 1'b0;
        ex_mret    = 1'b0;
        ex_illegal = 1'b0;
        instret    = 1'b0;
        timer_irq  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic csr(input csr_op_t op, input logic [11:0] a, input logic [31:0] d);
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr(CSR_OP_RW, a, d);
        step();
    endtask

    task automatic rd_check(input logic [11:0] a, input logic [31:0] v,
                            input logic stl, input string name);
        csr(CSR_OP_RS, a, 32'd0);
        stall = stl;
        expect_v(S_RDATA, v, name);
        expect_v(S_ILL, 32'd0, {name, "_ill"});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Held in reset: outputs must be quiet even with an illegal access and ECALL.
        csr(CSR_OP_RW, 12'hC00, 32'h1234);
        ex_ecall = 1'b1;
        ex_pc    = 32'h40;
        expect_v(S_ILL,   32'd0, "rst_ill");
        expect_v(S_RED,   32'd0, "rst_red");
        expect_v(S_TPC,   32'd0, "rst_tpc");
        expect_v(S_RDATA, 32'd0, "rst_rdata");
        step();
        rst = 1'b0;

        expect_v(S_PRIV, 32'd3, "reset_priv");
        rd_check(CSR_MTVEC,   32'h0,         1'b0, "reset_mtvec");
        rd_check(CSR_MSTATUS, 32'h0,         1'b0, "reset_mstatus");
        rd_check(CSR_MISA,    32'h4010_0100, 1'b0, "misa");
        rd_check(CSR_MHARTID, 32'h0,         1'b0, "mhartid");
        expect_v(S_SATP, 32'd0, "reset_satp");

        // mtvec low bits forced to zero; old value returned on the write.
        csr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0103);
        expect_v(S_RDATA, 32'h0, "mtvec_wr_old");
        step();
        rd_check(CSR_MTVEC, 32'h8000_0100, 1'b0, "mtvec_aligned");

        // Set on mscratch: old value now, merged value next cycle.
        wr(CSR_MSCRATCH, 32'h0F);
        csr(CSR_OP_RS, CSR_MSCRATCH, 32'hF0);
        expect_v(S_RDATA, 32'h0F, "rs_old");
        step();
        rd_check(CSR_MSCRATCH, 32'hFF, 1'b0, "rs_new");

        // Zero-mask clear on read-only-valued misa is not a write.
        csr(CSR_OP_RC, CSR_MISA, 32'h0);
        expect_v(S_ILL, 32'd0, "rc0_misa_ill");
        expect_v(S_RED, 32'd0, "rc0_misa_red");
        step();

        // Write to read-only space traps as illegal.
        csr(CSR_OP_RW, CSR_MHARTID, 32'h5);
        ex_instr = 32'h1234_5073;
        expect_v(S_ILL, 32'd1, "ro_wr_ill");
        expect_v(S_RED, 32'd1, "ro_wr_red");
        expect_v(S_TPC, 32'h8000_0100, "ro_wr_tpc");
        step();
        rd_check(CSR_MCAUSE, 32'd2,         1'b0, "ro_wr_mcause");
        rd_check(CSR_MTVAL,  32'h1234_5073, 1'b0, "ro_wr_mtval");

        // Unimplemented address is illegal.
        csr(CSR_OP_RS, 12'h7C0, 32'h0);
        expect_v(S_ILL, 32'd1, "unimpl_ill");
        step();

        // ECALL from M.
        wr(CSR_MTVEC, 32'h200);
        ex_ecall = 1'b1;
        ex_pc    = 32'h100;
        expect_v(S_RED, 32'd1, "ecall_red");
        expect_v(S_TPC, 32'h200, "ecall_tpc");
        step();
        rd_check(CSR_MEPC,    32'h100,  1'b0, "ecall_mepc");
        rd_check(CSR_MCAUSE,  32'd11,   1'b0, "ecall_mcause");
        rd_check(CSR_MSTATUS, 32'h1800, 1'b0, "ecall_mstatus");

        // Timer interrupt beats a concurrent mscratch write.
        wr(CSR_MSTATUS, 32'h8);
        wr(CSR_MIE, 32'h80);
        csr(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD);
        timer_irq = 1'b1;
        ex_valid  = 1'b1;
        ex_pc     = 32'h300;
        expect_v(S_RED,   32'd1,   "irq_red");
        expect_v(S_TPC,   32'h200, "irq_tpc");
        expect_v(S_RDATA, 32'hFF,  "irq_rdata_old");
        step();
        rd_check(CSR_MCAUSE,   32'h8000_0007, 1'b0, "irq_mcause");
        rd_check(CSR_MSCRATCH, 32'hFF,        1'b0, "irq_wr_suppressed");
        rd_check(CSR_MEPC,     32'h300,       1'b0, "irq_mepc");
        rd_check(CSR_MTVAL,    32'h0,         1'b0, "irq_mtval");
        rd_check(CSR_MSTATUS,  32'h1880,      1'b0, "irq_mstatus");
        timer_irq = 1'b1;
        rd_check(CSR_MIP, 32'h80, 1'b0, "mip_mtip");

        // MPP=10 legalizes to U.
        wr(CSR_MSTATUS, 32'h1000);
        rd_check(CSR_MSTATUS, 32'h0, 1'b0, "mpp_legal");

        // MRET to U.
        ex_mret = 1'b1;
        expect_v(S_RED, 32'd1,   "mret_red");
        expect_v(S_TPC, 32'h300, "mret_tpc");
        step();
        expect_v(S_PRIV, 32'd0, "u_priv");

        // CSR access from U is illegal and re-enters M.
        csr(CSR_OP_RW, CSR_MSTATUS, 32'h8);
        ex_instr = 32'hABCD_1073;
        ex_pc    = 32'h400;
        expect_v(S_ILL, 32'd1,   "u_csr_ill");
        expect_v(S_RED, 32'd1,   "u_csr_red");
        expect_v(S_TPC, 32'h200, "u_csr_tpc");
        step();
        expect_v(S_PRIV, 32'd3, "u_csr_priv");
        rd_check(CSR_MCAUSE,  32'd2,         1'b0, "u_csr_mcause");
        rd_check(CSR_MTVAL,   32'hABCD_1073, 1'b0, "u_csr_mtval");
        rd_check(CSR_MEPC,    32'h400,       1'b0, "u_csr_mepc");
        rd_check(CSR_MSTATUS, 32'h0,         1'b0, "u_csr_mstatus");

        // MRET while in U is illegal.
        ex_mret = 1'b1;
        step();
        ex_mret  = 1'b1;
        ex_pc    = 32'h500;
        ex_instr = 32'h3020_0073;
        expect_v(S_RED, 32'd1,   "u_mret_red");
        expect_v(S_TPC, 32'h200, "u_mret_tpc");
        expect_v(S_ILL, 32'd0,   "u_mret_csr_ill");
        step();
        rd_check(CSR_MCAUSE, 32'd2,         1'b0, "u_mret_mcause");
        rd_check(CSR_MTVAL,  32'h3020_0073, 1'b0, "u_mret_mtval");

        // ECALL from U, EBREAK from M.
        ex_mret = 1'b1;
        expect_v(S_TPC, 32'h500, "mret2_tpc");
        step();
        ex_ecall = 1'b1;
        ex_pc    = 32'h600;
        step();
        expect_v(S_PRIV, 32'd3, "ecall_u_priv");
        rd_check(CSR_MCAUSE, 32'd8, 1'b0, "ecall_u_mcause");
        ex_ebreak = 1'b1;
        ex_pc     = 32'h700;
        expect_v(S_TPC, 32'h200, "ebreak_tpc");
        step();
        rd_check(CSR_MCAUSE, 32'd3,   1'b0, "ebreak_mcause");
        rd_check(CSR_MTVAL,  32'h700, 1'b0, "ebreak_mtval");

        // satp export.
        wr(CSR_SATP, 32'h8000_1234);
        expect_v(S_SATP, 32'h8000_1234, "satp_o");
        step();

        // Stall freezes state and suppresses redirect; read data stays valid.
        csr(CSR_OP_RW, CSR_MSCRATCH, 32'h55);
        stall    = 1'b1;
        ex_ecall = 1'b1;
        expect_v(S_RED,   32'd0,  "stall_red");
        expect_v(S_RDATA, 32'hFF, "stall_rdata");
        step();
        rd_check(CSR_MSCRATCH, 32'hFF, 1'b0, "stall_no_wr");

`ifdef CSR_COUNTERS_EN
        wr(CSR_MCYCLE, 32'hFFFF_FFFF);
        rd_check(CSR_MCYCLE,  32'hFFFF_FFFF, 1'b1, "mcycle_wr");
        rd_check(CSR_MCYCLE,  32'hFFFF_FFFF, 1'b1, "mcycle_stall");
        step();
        rd_check(CSR_MCYCLEH, 32'h1,         1'b1, "mcycleh_carry");
        rd_check(CSR_MCYCLE,  32'h0,         1'b1, "mcycle_wrap");
        csr(CSR_OP_RW, CSR_MINSTRET, 32'h5);
        instret = 1'b1;
        step();
        rd_check(CSR_MINSTRET, 32'h5, 1'b1, "minstret_wr");
        instret = 1'b1;
        step();
        rd_check(CSR_MINSTRET, 32'h6, 1'b1, "minstret_inc");
`else
        csr(CSR_OP_RS, CSR_MCYCLE, 32'h0);
        expect_v(S_ILL, 32'd1, "mcycle_absent_ill");
        step();
        csr(CSR_OP_RS, CSR_MINSTRETH, 32'h0);
        expect_v(S_ILL, 32'd1, "minstreth_absent_ill");
        step();
`endif

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
